// File: rtl/cw_capture_ctrl.sv
// ---------------------------------------------------------------------------
// cw_capture_ctrl
//  Trace-buffer write sequencer for the on-chip watcher. On arm it fills a
//  circular pre-trigger window, waits for a qualified trigger sample, stores
//  a fixed number of post-trigger samples, then stops with done held high.
//
// Ports
//  trig_clk_i    capture clock
//  trig_rst_i    asynchronous reset, active-high
//  arm_i         start a capture (level, sampled every cycle while idle/done)
//  abort_i       cancel capture, return to idle (wins over arm_i)
//  samp_en_i     storage qualifier; a sample is written only when high
//  trig_hit_i    trigger condition for the current sample
//  pre_len_i     samples required before a trigger is accepted (latched on arm)
//  post_len_i    samples stored after the trigger sample (latched on arm)
//  wt_ce_o       capture RAM enable, registered, high while capturing
//  wt_en_o       capture RAM write strobe = wt_ce_o & samp_en_i
//  wt_addr_o     capture RAM write address, registered
//  trig_addr_o   address at which the trigger sample was written
//  wrapped_o     write pointer has wrapped DEPTH-1 -> 0 during this capture
//  done_o        capture complete, buffer contents stable
// ---------------------------------------------------------------------------
module cw_capture_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1365
) (
  input  logic              trig_clk_i,
  input  logic              trig_rst_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              samp_en_i,
  input  logic              trig_hit_i,
  input  logic [ADDR_W-1:0] pre_len_i,
  input  logic [ADDR_W-1:0] post_len_i,
  output logic              wt_ce_o,
  output logic              wt_en_o,
  output logic [ADDR_W-1:0] wt_addr_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic              wrapped_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  // Highest legal address; DEPTH need not be a power of two, so the pointer
  // wraps explicitly at this value rather than by natural overflow.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   cnt_q,       cnt_d;
  logic [ADDR_W-1:0]   pre_c_q,     pre_c_d;
  logic [ADDR_W-1:0]   post_c_q,    post_c_d;
  logic                wrapped_q,   wrapped_d;
  logic                ce_q,        ce_d;
  logic                done_q,      done_d;

  // Length clamping: the post window takes priority, and pre + post + the
  // trigger sample itself must fit in DEPTH so no stored sample is overwritten.
  logic [ADDR_W-1:0]   post_clamp;
  logic [ADDR_W-1:0]   pre_room;
  logic [ADDR_W-1:0]   pre_clamp;

  always_comb begin
    post_clamp = (post_len_i > LAST_ADDR) ? LAST_ADDR : post_len_i;
    pre_room   = LAST_ADDR - post_clamp;
    pre_clamp  = (pre_len_i > pre_room) ? pre_room : pre_len_i;
  end

  // A qualified write: RAM enabled and the sample is marked for storage.
  logic wr_en;
  logic at_last;

  assign wr_en   = ce_q & samp_en_i;
  assign at_last = (addr_q == LAST_ADDR);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trig_addr_d = trig_addr_q;
    cnt_d       = cnt_q;
    pre_c_d     = pre_c_q;
    post_c_d    = post_c_q;
    wrapped_d   = wrapped_q;

    if (abort_i) begin
      // Pointers are left untouched so the readout can still inspect them.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            pre_c_d   = pre_clamp;
            post_c_d  = post_clamp;
            addr_d    = '0;
            wrapped_d = 1'b0;
            cnt_d     = '0;
            state_d   = (pre_clamp != '0) ? S_PRE : S_WAIT;
          end
        end
        S_PRE: begin
          if (wr_en) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if ((cnt_q + ADDR_W'(1)) == pre_c_q) begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wr_en && trig_hit_i) begin
            trig_addr_d = addr_q;
            cnt_d       = post_c_q;
            state_d     = (post_c_q == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (wr_en) begin
            cnt_d = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      // wr_en is only possible in PRE/WAIT/POST, so this never collides with
      // the pointer clear done on arm.
      if (wr_en) begin
        addr_d = at_last ? '0 : addr_q + ADDR_W'(1);
        if (at_last) begin
          wrapped_d = 1'b1;
        end
      end
    end

    ce_d   = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge trig_clk_i or posedge trig_rst_i) begin
    if (trig_rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      trig_addr_q <= '0;
      cnt_q       <= '0;
      pre_c_q     <= '0;
      post_c_q    <= '0;
      wrapped_q   <= 1'b0;
      ce_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trig_addr_q <= trig_addr_d;
      cnt_q       <= cnt_d;
      pre_c_q     <= pre_c_d;
      post_c_q    <= post_c_d;
      wrapped_q   <= wrapped_d;
      ce_q        <= ce_d;
      done_q      <= done_d;
    end
  end

  assign wt_ce_o     = ce_q;
  assign wt_en_o     = wr_en;
  assign wt_addr_o   = addr_q;
  assign trig_addr_o = trig_addr_q;
  assign wrapped_o   = wrapped_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_cw_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cw_capture_ctrl
//  Drives a DEPTH=8 instance and a DEPTH=1365 instance with shared stimulus.
//  The reference model tracks a capture as a count of stored samples and the
//  index of the trigger sample; addresses and flags follow arithmetically.
// ---------------------------------------------------------------------------
module tb_cw_capture_ctrl;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        abort;
  logic        samp_en;
  logic        trig_hit;
  logic [15:0] pre_len;
  logic [15:0] post_len;

  logic        ce_s, en_s, wr_s, done_s;
  logic [3:0]  addr_s, trig_s;
  logic        ce_b, en_b, wr_b, done_b;
  logic [15:0] addr_b, trig_b;

  cw_capture_ctrl #(.ADDR_W(4), .DEPTH(8)) dut_small (
    .trig_clk_i (clk),
    .trig_rst_i (rst),
    .arm_i      (arm),
    .abort_i    (abort),
    .samp_en_i  (samp_en),
    .trig_hit_i (trig_hit),
    .pre_len_i  (pre_len[3:0]),
    .post_len_i (post_len[3:0]),
    .wt_ce_o    (ce_s),
    .wt_en_o    (en_s),
    .wt_addr_o  (addr_s),
    .trig_addr_o(trig_s),
    .wrapped_o  (wr_s),
    .done_o     (done_s)
  );

  cw_capture_ctrl #(.ADDR_W(16), .DEPTH(1365)) dut_big (
    .trig_clk_i (clk),
    .trig_rst_i (rst),
    .arm_i      (arm),
    .abort_i    (abort),
    .samp_en_i  (samp_en),
    .trig_hit_i (trig_hit),
    .pre_len_i  (pre_len),
    .post_len_i (post_len),
    .wt_ce_o    (ce_b),
    .wt_en_o    (en_b),
    .wt_addr_o  (addr_b),
    .trig_addr_o(trig_b),
    .wrapped_o  (wr_b),
    .done_o     (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which instance is being observed, and its depth.
  bit big;
  int D;

  logic        obs_ce, obs_en, obs_wrapped, obs_done;
  int          obs_addr, obs_trig;
  logic [19:0] obs_vec;

  always_comb begin
    obs_ce      = big ? ce_b   : ce_s;
    obs_en      = big ? en_b   : en_s;
    obs_wrapped = big ? wr_b   : wr_s;
    obs_done    = big ? done_b : done_s;
    obs_addr    = big ? int'(addr_b) : int'(addr_s);
    obs_trig    = big ? int'(trig_b) : int'(trig_s);
    obs_vec     = {obs_ce, obs_en, obs_done, obs_wrapped, 16'(obs_addr)};
  end

  int n_checks;
  int n_pass;

  // Reference model: capture described by samples stored so far (m_n) and the
  // index of the trigger sample within the capture (m_t, -1 if none yet).
  bit m_active;
  bit m_done;
  int m_n;
  int m_t;
  int m_pre;
  int m_post;
  int m_trig;

  function automatic void model_reset();
    m_active = 0;
    m_done   = 0;
    m_n      = 0;
    m_t      = -1;
    m_pre    = 0;
    m_post   = 0;
    m_trig   = 0;
  endfunction

  // {wt_ce, wt_en, done, wrapped, wt_addr} expected for the current cycle.
  function automatic logic [19:0] exp_vec();
    logic [15:0] a;
    logic        w;
    a = 16'(m_n % D);
    w = (m_n >= D);
    return {m_active, m_active & samp_en, m_done, w, a};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void tick_model();
    int p;
    int q;
    if (abort) begin
      m_active = 0;
      m_done   = 0;
    end else if (!m_active && arm) begin
      q        = int'(post_len);
      p        = int'(pre_len);
      m_post   = (q > D - 1) ? D - 1 : q;
      m_pre    = (p > D - 1 - m_post) ? D - 1 - m_post : p;
      m_n      = 0;
      m_t      = -1;
      m_active = 1;
      m_done   = 0;
    end else if (m_active && samp_en) begin
      if (m_t < 0 && trig_hit && m_n >= m_pre) begin
        m_t    = m_n;
        m_trig = m_n % D;
      end
      m_n = m_n + 1;
      if (m_t >= 0 && m_n == m_t + 1 + m_post) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endfunction

  task automatic drive(input bit a, input bit ab, input bit s, input bit h,
                       input int pre, input int post);
    @(negedge clk);
    arm      = a;
    abort    = ab;
    samp_en  = s;
    trig_hit = h;
    pre_len  = 16'(pre);
    post_len = 16'(post);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    arm      = 1'b0;
    abort    = 1'b0;
    samp_en  = 1'b0;
    trig_hit = 1'b0;
    pre_len  = '0;
    post_len = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    big = 0; D = 8;
    #1;
    n_checks++;
    if (obs_vec !== exp_vec()) $display("FAIL reset_state got %h want %h", obs_vec, exp_vec());
    else n_pass++;
    n_checks++;
    if (obs_trig !== 0) $display("FAIL reset_trig_addr got %0d want 0", obs_trig);
    else n_pass++;
    // Start a capture, then pulse reset between clock edges.
    drive(1, 0, 1, 0, 3, 2); tick_model();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, (k == 3), 0, 0); tick_model();
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({obs_ce, obs_done, obs_wrapped, 16'(obs_addr), 16'(obs_trig)} !== 35'd0)
      $display("FAIL async_reset got ce=%b done=%b wrapped=%b addr=%0d trig=%0d want all 0",
               obs_ce, obs_done, obs_wrapped, obs_addr, obs_trig);
    else n_pass++;
    model_reset();
    arm = 0; abort = 0; samp_en = 0; trig_hit = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs_vec !== exp_vec()) $display("FAIL after_reset got %h want %h", obs_vec, exp_vec());
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int writes;
    writes = 0;
    big = 0; D = 8;
    drive(1, 0, 1, 0, 3, 2);
    n_checks++;
    if (obs_vec !== exp_vec()) $display("FAIL t1_arm got %h want %h", obs_vec, exp_vec());
    else n_pass++;
    tick_model();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, (k == 3), 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL t1_cyc%0d got %h want %h", k, obs_vec, exp_vec());
      else n_pass++;
      if (obs_en) begin
        n_checks++;
        if (obs_addr != writes) $display("FAIL t1_addr got %0d want %0d", obs_addr, writes);
        else n_pass++;
        writes++;
      end
      tick_model();
    end
    n_checks++;
    if (writes != 6) $display("FAIL t1_writes got %0d want 6", writes); else n_pass++;
    n_checks++;
    if (obs_trig != 3) $display("FAIL t1_trig_addr got %0d want 3", obs_trig); else n_pass++;
    n_checks++;
    if (obs_wrapped !== 1'b0 || obs_done !== 1'b1)
      $display("FAIL t1_flags got wrapped=%b done=%b want 0 1", obs_wrapped, obs_done);
    else n_pass++;
    $display("test_basic: writes=%0d trig_addr=%0d", writes, obs_trig);
  endtask

  task automatic test_wrap();
    int writes;
    writes = 0;
    big = 0; D = 8;
    drive(1, 0, 1, 0, 2, 1); tick_model();
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, (k >= 10), 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL t2_cyc%0d got %h want %h", k, obs_vec, exp_vec());
      else n_pass++;
      if (obs_en) writes++;
      tick_model();
    end
    n_checks++;
    if (writes != 12) $display("FAIL t2_writes got %0d want 12", writes); else n_pass++;
    n_checks++;
    if (obs_trig != 2) $display("FAIL t2_trig_addr got %0d want 2", obs_trig); else n_pass++;
    n_checks++;
    if (((obs_trig - 2 + 8) % 8) != 0)
      $display("FAIL t2_oldest got %0d want 0", (obs_trig - 2 + 8) % 8);
    else n_pass++;
    n_checks++;
    if (obs_wrapped !== 1'b1 || obs_done !== 1'b1)
      $display("FAIL t2_flags got wrapped=%b done=%b want 1 1", obs_wrapped, obs_done);
    else n_pass++;
    $display("test_wrap: writes=%0d trig_addr=%0d", writes, obs_trig);
  endtask

  task automatic test_clamp();
    int writes;
    writes = 0;
    big = 0; D = 8;
    // Trigger asserted in the arm cycle must not count.
    drive(1, 0, 1, 1, 9, 9); tick_model();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 1, 1, 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL t3_cyc%0d got %h want %h", k, obs_vec, exp_vec());
      else n_pass++;
      if (obs_en) writes++;
      tick_model();
    end
    n_checks++;
    if (writes != 8) $display("FAIL t3_writes got %0d want 8", writes); else n_pass++;
    n_checks++;
    if (obs_trig != 0) $display("FAIL t3_trig_addr got %0d want 0", obs_trig); else n_pass++;
    $display("test_clamp: writes=%0d trig_addr=%0d", writes, obs_trig);
  endtask

  task automatic test_qualifier();
    int writes;
    bit s;
    writes = 0;
    big = 0; D = 8;
    drive(1, 0, 0, 0, 0, 1); tick_model();
    for (int k = 0; k < 12; k++) begin
      s = (k % 2 == 0);
      drive(0, 0, s, !s, 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL t4_cyc%0d got %h want %h", k, obs_vec, exp_vec());
      else n_pass++;
      if (obs_en) writes++;
      tick_model();
    end
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_addr != 6 || obs_done !== 1'b0 || obs_ce !== 1'b1)
      $display("FAIL t4_no_trigger got addr=%0d done=%b ce=%b want 6 0 1", obs_addr, obs_done, obs_ce);
    else n_pass++;
    tick_model();
    drive(0, 1, 0, 0, 0, 0); tick_model();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_vec !== exp_vec()) $display("FAIL t4_abort got %h want %h", obs_vec, exp_vec());
    else n_pass++;
    tick_model();
    $display("test_qualifier: writes=%0d", writes);
  endtask

  task automatic test_abort();
    big = 0; D = 8;
    drive(1, 0, 1, 0, 1, 3); tick_model();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, (k == 1), 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL t5_cyc%0d got %h want %h", k, obs_vec, exp_vec());
      else n_pass++;
      tick_model();
    end
    drive(1, 1, 1, 0, 1, 3); tick_model();
    drive(1, 0, 1, 0, 1, 3);
    n_checks++;
    if (obs_ce !== 1'b0 || obs_done !== 1'b0 || obs_addr != 3)
      $display("FAIL t5_after_abort got ce=%b done=%b addr=%0d want 0 0 3", obs_ce, obs_done, obs_addr);
    else n_pass++;
    tick_model();
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if (obs_ce !== 1'b1 || obs_en !== 1'b1 || obs_addr != 0)
      $display("FAIL t5_rearm got ce=%b en=%b addr=%0d want 1 1 0", obs_ce, obs_en, obs_addr);
    else n_pass++;
    tick_model();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 1, 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL t5_tail%0d got %h want %h", k, obs_vec, exp_vec());
      else n_pass++;
      tick_model();
    end
    $display("test_abort: final addr=%0d done=%b", obs_addr, obs_done);
  endtask

  task automatic test_big_depth();
    int writes;
    int bad;
    writes = 0;
    bad = 0;
    do_reset();
    big = 1; D = 1365;
    drive(1, 0, 1, 0, 0, 1364); tick_model();
    for (int k = 0; k < 1370; k++) begin
      drive(0, 0, 1, 1, 0, 0);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        if (bad < 5) $display("FAIL t6_cyc%0d got %h want %h", k, obs_vec, exp_vec());
        bad++;
      end else n_pass++;
      if (obs_en) writes++;
      tick_model();
    end
    n_checks++;
    if (writes != 1365) $display("FAIL t6_writes got %0d want 1365", writes); else n_pass++;
    n_checks++;
    if (obs_addr != 0 || obs_wrapped !== 1'b1 || obs_done !== 1'b1)
      $display("FAIL t6_end got addr=%0d wrapped=%b done=%b want 0 1 1", obs_addr, obs_wrapped, obs_done);
    else n_pass++;
    $display("test_big_depth: writes=%0d", writes);
  endtask

  task automatic test_random();
    int bad;
    bit a, ab, s, h;
    int p, q;
    bad = 0;
    do_reset();
    big = 0; D = 8;
    for (int k = 0; k < 2000; k++) begin
      a  = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) != 0);
      h  = ($urandom_range(0, 2) == 0);
      p  = int'($urandom_range(0, 15));
      q  = int'($urandom_range(0, 15));
      drive(a, ab, s, h, p, q);
      n_checks++;
      if (obs_vec !== exp_vec() || obs_trig != m_trig) begin
        if (bad < 5) $display("FAIL rnd_cyc%0d got %h trig=%0d want %h trig=%0d",
                              k, obs_vec, obs_trig, exp_vec(), m_trig);
        bad++;
      end else n_pass++;
      tick_model();
    end
    $display("test_random: mismatching cycles=%0d", bad);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    big      = 0;
    D        = 8;
    rst      = 1'b1;
    arm      = 1'b0;
    abort    = 1'b0;
    samp_en  = 1'b0;
    trig_hit = 1'b0;
    pre_len  = '0;
    post_len = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_basic();
    test_wrap();
    test_clamp();
    test_qualifier();
    test_abort();
    test_big_depth();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
